// File: rtl/alu_pg_managed.sv
// Power-managed ALU leaf: ready/valid ALU datapath with retained result/flags and an
// ACTIVE/IDLE/ISOLATE/GATED/WAKE controller driving clock-enable, isolation and power switch.
module alu_pg_managed #(
  parameter int WIDTH          = 8,
  parameter int IDLE_THRESHOLD = 5,
  parameter int GATE_DELAY     = 2,
  parameter int WAKE_LATENCY   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opcode,
  input  logic             sleep_req,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             idle_detect,
  output logic [2:0]       power_state,
  output logic             clk_en,
  output logic             iso_en,
  output logic             pwr_on
);

  localparam int IW = $clog2(IDLE_THRESHOLD + 1);
  localparam int GW = $clog2(GATE_DELAY + 1);
  localparam int WW = $clog2(WAKE_LATENCY + 1);

  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_THRESHOLD - 1);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_DELAY - 1);
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_LATENCY - 1);

  typedef enum logic [2:0] {
    ACTIVE  = 3'd0,
    IDLE    = 3'd1,
    ISOLATE = 3'd2,
    GATED   = 3'd3,
    WAKE    = 3'd4
  } pstate_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_t;

  pstate_t         state;
  logic [IW-1:0]   idle_cnt;
  logic [GW-1:0]   gate_cnt;
  logic [WW-1:0]   wake_cnt;
  logic            accept;
  logic [WIDTH:0]  sum_ext;
  logic [WIDTH-1:0] alu_res;
  logic            alu_carry;

  assign in_ready = (state == ACTIVE) || (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign sum_ext  = {1'b0, A} + {1'b0, B};

  // Carry doubles as borrow for sub and as the shifted-out bit for shifts.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_t'(opcode))
      OP_ADD: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
      end
      OP_SUB: begin
        alu_res   = A - B;
        alu_carry = (A < B);
      end
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_XOR: alu_res = A ^ B;
      OP_NOT: alu_res = ~A;
      OP_SHL: begin
        alu_res   = {A[WIDTH-2:0], 1'b0};
        alu_carry = A[WIDTH-1];
      end
      OP_SHR: begin
        alu_res   = {1'b0, A[WIDTH-1:1]};
        alu_carry = A[0];
      end
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  // Result and flags are retention state: only an accept or reset may touch them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        result <= alu_res;
        carry  <= alu_carry;
        zero   <= (alu_res == '0);
      end
    end
  end

  // Power controller; an accept always beats sleep_req in ACTIVE and IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ACTIVE;
      idle_cnt <= '0;
      gate_cnt <= '0;
      wake_cnt <= '0;
    end else begin
      case (state)
        ACTIVE: begin
          if (accept) begin
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
            if (sleep_req) begin
              state <= ISOLATE;
            end else if (idle_cnt == IDLE_LAST) begin
              state    <= IDLE;
              gate_cnt <= '0;
            end
          end
        end
        IDLE: begin
          if (accept) begin
            state    <= ACTIVE;
            idle_cnt <= '0;
          end else if (sleep_req || gate_cnt == GATE_LAST) begin
            state <= ISOLATE;
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
          end
        end
        ISOLATE: state <= GATED;
        GATED: begin
          if (in_valid) begin
            state    <= WAKE;
            wake_cnt <= '0;
          end
        end
        WAKE: begin
          if (wake_cnt == WAKE_LAST) begin
            state    <= ACTIVE;
            idle_cnt <= '0;
          end else begin
            wake_cnt <= wake_cnt + 1'b1;
          end
        end
        default: state <= ACTIVE;
      endcase
    end
  end

  assign power_state = state;
  assign idle_detect = (state == IDLE) || (state == ISOLATE) || (state == GATED);
  assign clk_en      = (state != GATED);
  assign pwr_on      = (state != GATED);
  assign iso_en      = (state == ISOLATE) || (state == GATED) || (state == WAKE);

endmodule

// File: tb/tb_alu_pg_managed.sv
// Self-checking bench for alu_pg_managed: directed power-sequence checks plus
// randomized traffic compared every cycle against a behavioural model.
module tb_alu_pg_managed;

  localparam int WIDTH = 8;
  localparam int TH    = 5;
  localparam int GD    = 2;
  localparam int WL    = 3;
  localparam int MODV  = 1 << WIDTH;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       opcode;
  logic             sleep_req;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             idle_detect;
  logic [2:0]       power_state;
  logic             clk_en;
  logic             iso_en;
  logic             pwr_on;

  int checks = 0;
  int errors = 0;
  logic compare_en = 1'b0;

  alu_pg_managed #(
    .WIDTH(WIDTH), .IDLE_THRESHOLD(TH), .GATE_DELAY(GD), .WAKE_LATENCY(WL)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .opcode(opcode), .sleep_req(sleep_req),
    .out_valid(out_valid), .result(result), .carry(carry), .zero(zero),
    .idle_detect(idle_detect), .power_state(power_state),
    .clk_en(clk_en), .iso_en(iso_en), .pwr_on(pwr_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic s);
    in_valid  = v;
    opcode    = op;
    A         = a;
    B         = b;
    sleep_req = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU in plain integer arithmetic; returns {carry, result}.
  function automatic logic [WIDTH:0] model_alu(input logic [2:0] op, input int a, input int b);
    int r;
    logic c;
    logic [31:0] rv;
    c = 1'b0;
    case (op)
      3'd0: begin r = a + b; c = (r >= MODV); r = r % MODV; end
      3'd1: begin r = a - b; c = (a < b); if (r < 0) r = r + MODV; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = MODV - 1 - a;
      3'd6: begin c = (a >= MODV / 2); r = (a * 2) % MODV; end
      default: begin c = (a % 2) == 1; r = a / 2; end
    endcase
    rv = r;
    return {c, rv[WIDTH-1:0]};
  endfunction

  // Behavioural model: state as 0..4, counters as "how many cycles so far".
  int               m_state;
  int               m_quiet;
  int               m_gate;
  int               m_wake;
  logic [WIDTH-1:0] m_result;
  logic             m_carry;
  logic             m_zero;
  logic             m_valid;
  logic             m_acc;
  logic [WIDTH:0]   m_alu;

  assign m_acc = in_valid && (m_state == 0 || m_state == 1);
  assign m_alu = model_alu(opcode, int'(A), int'(B));

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state  <= 0;
      m_quiet  <= 0;
      m_gate   <= 0;
      m_wake   <= 0;
      m_result <= '0;
      m_carry  <= 1'b0;
      m_zero   <= 1'b1;
      m_valid  <= 1'b0;
    end else begin
      m_valid <= m_acc;
      if (m_acc) begin
        m_result <= m_alu[WIDTH-1:0];
        m_carry  <= m_alu[WIDTH];
        m_zero   <= (m_alu[WIDTH-1:0] == 0);
      end
      case (m_state)
        0: begin
          if (m_acc) m_quiet <= 0;
          else if (sleep_req) m_state <= 2;
          else if (m_quiet + 1 == TH) begin m_state <= 1; m_gate <= 0; end
          else m_quiet <= m_quiet + 1;
        end
        1: begin
          if (m_acc) begin m_state <= 0; m_quiet <= 0; end
          else if (sleep_req || m_gate + 1 == GD) m_state <= 2;
          else m_gate <= m_gate + 1;
        end
        2: m_state <= 3;
        3: if (in_valid) begin m_state <= 4; m_wake <= 0; end
        default: begin
          if (m_wake + 1 == WL) begin m_state <= 0; m_quiet <= 0; end
          else m_wake <= m_wake + 1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (compare_en && !reset) begin
      checkOutput("out_valid", out_valid, m_valid);
      checkOutput("result", result, m_result);
      checkOutput("carry", carry, m_carry);
      checkOutput("zero", zero, m_zero);
      checkOutput("power_state", power_state, m_state);
      checkOutput("in_ready", in_ready, (m_state == 0 || m_state == 1));
      checkOutput("idle_detect", idle_detect, (m_state >= 1 && m_state <= 3));
      checkOutput("clk_en", clk_en, (m_state != 3));
      checkOutput("pwr_on", pwr_on, (m_state != 3));
      checkOutput("iso_en", iso_en, (m_state >= 2));
    end
  end

  initial begin
    int mode;
    reset = 1'b1;
    applyStimulus(1'b0, 3'd0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    compare_en = 1'b1;

    checkOutput("rst_state", power_state, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_zero", zero, 1);
    checkOutput("rst_ready", in_ready, 1);
    checkOutput("rst_clk_en", clk_en, 1);
    checkOutput("rst_iso_en", iso_en, 0);

    repeat (5) tick();
    checkOutput("edge5_idle", power_state, 1);
    checkOutput("edge5_idle_detect", idle_detect, 1);
    repeat (2) tick();
    checkOutput("edge7_isolate", power_state, 2);
    checkOutput("edge7_ready", in_ready, 0);
    tick();
    checkOutput("edge8_gated", power_state, 3);
    checkOutput("gated_clk_en", clk_en, 0);
    checkOutput("gated_pwr_on", pwr_on, 0);
    checkOutput("gated_iso_en", iso_en, 1);
    checkOutput("gated_result", result, 0);

    applyStimulus(1'b1, 3'd0, 8'd2, 8'd3, 1'b0);
    tick();
    checkOutput("wake_k_state", power_state, 4);
    checkOutput("wake_k_ready", in_ready, 0);
    tick();
    checkOutput("wake_k1_ready", in_ready, 0);
    tick();
    checkOutput("wake_k2_ready", in_ready, 0);
    tick();
    checkOutput("wake_k3_active", power_state, 0);
    checkOutput("wake_k3_valid", out_valid, 0);
    tick();
    checkOutput("wake_k4_valid", out_valid, 1);
    checkOutput("wake_k4_result", result, 5);

    applyStimulus(1'b1, 3'd0, 8'hF0, 8'h20, 1'b0);
    tick();
    checkOutput("add_result", result, 8'h10);
    checkOutput("add_carry", carry, 1);
    checkOutput("add_zero", zero, 0);
    checkOutput("add_valid", out_valid, 1);
    applyStimulus(1'b1, 3'd1, 8'd3, 8'd5, 1'b0);
    tick();
    checkOutput("sub_result", result, 8'hFE);
    checkOutput("sub_borrow", carry, 1);
    applyStimulus(1'b1, 3'd6, 8'h81, 8'h00, 1'b0);
    tick();
    checkOutput("shl_result", result, 8'h02);
    checkOutput("shl_carry", carry, 1);
    applyStimulus(1'b1, 3'd4, 8'h5A, 8'h5A, 1'b0);
    tick();
    checkOutput("xor_result", result, 8'h00);
    checkOutput("xor_zero", zero, 1);
    checkOutput("xor_carry", carry, 0);
    applyStimulus(1'b0, 3'd0, '0, '0, 1'b0);
    tick();
    checkOutput("valid_drop", out_valid, 0);
    repeat (3) tick();
    checkOutput("quiet4_active", power_state, 0);
    tick();
    checkOutput("quiet5_idle", power_state, 1);

    applyStimulus(1'b1, 3'd3, 8'h0C, 8'h30, 1'b0);
    tick();
    checkOutput("idle_accept_state", power_state, 0);
    checkOutput("or_result", result, 8'h3C);
    applyStimulus(1'b0, 3'd0, '0, '0, 1'b0);
    repeat (4) tick();
    checkOutput("reidle4_active", power_state, 0);
    tick();
    checkOutput("reidle5_idle", power_state, 1);

    applyStimulus(1'b1, 3'd0, 8'd1, 8'd1, 1'b0);
    tick();
    applyStimulus(1'b1, 3'd1, 8'd9, 8'd4, 1'b1);
    tick();
    checkOutput("sleep_accept_state", power_state, 0);
    checkOutput("sleep_accept_result", result, 5);
    checkOutput("sleep_accept_valid", out_valid, 1);
    applyStimulus(1'b0, 3'd0, '0, '0, 1'b1);
    tick();
    checkOutput("sleep_isolate", power_state, 2);
    applyStimulus(1'b0, 3'd0, '0, '0, 1'b0);
    tick();
    checkOutput("sleep_gated", power_state, 3);
    checkOutput("sleep_retained", result, 5);

    applyStimulus(1'b1, 3'd0, 8'd7, 8'd7, 1'b0);
    tick();
    checkOutput("pre_reset_wake", power_state, 4);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_state", power_state, 0);
    checkOutput("async_result", result, 0);
    checkOutput("async_zero", zero, 1);
    checkOutput("async_carry", carry, 0);
    checkOutput("async_valid", out_valid, 0);
    checkOutput("async_ready", in_ready, 1);
    checkOutput("async_clk_en", clk_en, 1);
    checkOutput("async_iso_en", iso_en, 0);
    checkOutput("async_pwr_on", pwr_on, 1);
    checkOutput("async_idle_detect", idle_detect, 0);
    applyStimulus(1'b0, 3'd0, '0, '0, 1'b0);
    #2 reset = 1'b0;

    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 48 == 0) mode = $urandom_range(0, 2);
      case (mode)
        0: applyStimulus($urandom_range(0, 99) < 75, 3'($urandom), 8'($urandom), 8'($urandom),
                         $urandom_range(0, 99) < 4);
        1: applyStimulus($urandom_range(0, 99) < 3, 3'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        default: applyStimulus($urandom_range(0, 99) < 30, 3'($urandom), 8'($urandom), 8'($urandom),
                               $urandom_range(0, 99) < 10);
      endcase
      tick();
    end
    applyStimulus(1'b0, 3'd0, '0, '0, 1'b0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
